lcd_sequencer: RTL and testbench
================================

Name: lcd_sequencer

Overview:
Controller that drives the 11-bit command word into the LCD display datapath (display block, SIZE data slots). After reset it runs the HD44780 power-up and init sequence. It then serves update requests: set the DDRAM address, then write data slots 1..SIZE-1 in order. Every write is followed by the controller-enforced execution delay. It sits between the clock/alarm core and the display block.

Parameters:
SIZE, 4, number of 8-bit data slots in the display block (multiple of 4); slots 1..SIZE-1 are written per update
WAIT_SHORT, 2000, cycles held after any normal command or data write (≥37 us at 50 MHz)
WAIT_LONG, 80000, cycles held after Clear Display (≥1.52 ms)
POWERUP, 1000000, cycles idle after reset before the first init command (≥20 ms)

Ports:
i_clk  in  1  system clock; also the LCD E strobe inside the display block
i_rst_n  in  1  asynchronous active-low reset
i_req  in  1  update request, sampled only when o_ready=1
i_addr  in  7  DDRAM start address for the update, captured with i_req
o_comm  out  11  command word to the display block
o_ready  out  1  high in IDLE only
o_busy  out  1  high from POWERUP through the end of the current update
o_done  out  1  one-cycle pulse after the last slot's wait completes

Behaviour:
- One clock. Reset is asynchronous and active-low on i_rst_n. All state registers are cleared asynchronously.
- o_comm fields: [10] selects the byte source (0 = literal in [7:0], 1 = data slot). [9] = RW. [8] = RS. [7:0] = literal byte, or slot index k-1 to select slot k.
- IDLE word 11'h200 (RW=1, RS=0: busy-flag read, harmless). o_comm carries this word every cycle in which no command is being issued.
- Reset values: o_comm=11'h200, o_ready=0, o_busy=1, o_done=0. The FSM enters POWERUP.
- FSM states: POWERUP → INIT_ISSUE → INIT_WAIT → (loop over 4 init entries) → IDLE → ADDR_ISSUE → ADDR_WAIT → DATA_ISSUE → DATA_WAIT → (loop k=1..SIZE-1) → IDLE.
- POWERUP: counts POWERUP cycles, then goes to INIT_ISSUE.
- Init ROM, in order: 0x38 (function set, 8-bit, 2 lines), 0x0C (display on), 0x01 (clear, uses WAIT_LONG), 0x06 (entry mode). Each is issued as {1'b0,2'b00,byte}.
- Every ISSUE state drives its non-idle word for exactly 1 cycle. The following WAIT state drives 11'h200 for exactly WAIT_SHORT cycles (WAIT_LONG for 0x01). The next state is entered on the cycle after the counter reaches 0.
- IDLE: o_ready=1 and o_busy=0. When i_req=1, i_addr is captured and the FSM goes to ADDR_ISSUE on the next cycle.
- ADDR_ISSUE drives {1'b0,2'b00,1'b1,addr}.
- DATA_ISSUE for slot k drives {1'b1,1'b0,1'b1,(k-1)[7:0]}: RS=1, RW=0.
- o_done pulses on the final DATA_WAIT→IDLE transition. It never asserts during init.
- i_req while not in IDLE is ignored, not queued. i_addr changes after capture have no effect.
- Reset asserted mid-operation: the block returns immediately to reset values and repeats the full POWERUP and init sequence.
- The wait counter width is $clog2 of the largest of WAIT_LONG and POWERUP, plus 1. The counter loads (N-1) and counts down to 0 with no wrap.

Optional Feature:
LCD_SEQ_AUTO_REFRESH_EN:
- Defined: adds parameter REFRESH (default 5000000). A free-running counter runs in all states after init. When it expires while in IDLE with i_req=0, an update with address 0x00 starts. The counter reloads on every update start, external or internal. An external i_req in the same IDLE cycle wins and uses i_addr.
- Undefined: updates occur only on i_req. No refresh counter is synthesized.

Decomposition:
- Package lcd_pkg holds:
  - state enum
  - field positions: SEL=10, RW=9, RS=8
  - IDLE_WORD=11'h200
  - init ROM constants
  - clear opcode 0x01 and set-DDRAM opcode 0x80
- One sub-module, lcd_wait_timer: loadable down-counter with a zero flag. It is shared by POWERUP and all WAIT states.

Test Plan:
- Reset, then run: o_comm=11'h200 for POWERUP cycles, then words 0x038, 0x00C, 0x001, 0x006, each high 1 cycle. Gaps are WAIT_SHORT, WAIT_SHORT, WAIT_LONG, WAIT_SHORT. o_ready rises after the last gap.
- IDLE, i_req=1 with i_addr=0x40, SIZE=4: sequence 11'h0C0, 11'h500, 11'h501, 11'h502, each separated by WAIT_SHORT idle words. o_done pulses once, then o_ready=1.
- i_req held high during init and during an update: no extra update starts. Exactly one update follows once IDLE is reached with i_req still high.
- i_rst_n pulsed low during DATA_WAIT: o_comm=11'h200, o_busy=1, o_done=0 immediately (asynchronous). The full init is repeated.
- With LCD_SEQ_AUTO_REFRESH_EN and REFRESH=100 (sim): with no i_req, an address-0x00 update starts every ~100 cycles. A simultaneous i_req with i_addr=0x10 produces 11'h090 instead.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the LCD command sequencer
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT_ISSUE,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_ADDR_ISSUE,
    ST_ADDR_WAIT,
    ST_DATA_ISSUE,
    ST_DATA_WAIT
  } lcd_state_e;

  localparam int SEL_BIT = 10;
  localparam int RW_BIT  = 9;
  localparam int RS_BIT  = 8;

  localparam logic [10:0] IDLE_WORD = 11'h200;

  localparam int         INIT_LEN      = 4;
  localparam logic [7:0] OP_FUNC_SET   = 8'h38;
  localparam logic [7:0] OP_DISP_ON    = 8'h0C;
  localparam logic [7:0] OP_CLEAR      = 8'h01;
  localparam logic [7:0] OP_ENTRY_MODE = 8'h06;
  localparam logic [7:0] OP_SET_DDRAM  = 8'h80;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    logic [7:0] op;
    case (idx)
      2'd0:    op = OP_FUNC_SET;
      2'd1:    op = OP_DISP_ON;
      2'd2:    op = OP_CLEAR;
      default: op = OP_ENTRY_MODE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// rtl/lcd_wait_timer.sv - loadable down-counter with zero flag, holds at zero
module lcd_wait_timer #(
  parameter int             W         = 8,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Reset value lets the power-up delay start without an explicit load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - HD44780 init and update sequencer; optional LCD_SEQ_AUTO_REFRESH_EN
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int SIZE       = 4,
  parameter int WAIT_SHORT = 2000,
  parameter int WAIT_LONG  = 80000,
  parameter int POWERUP    = 1000000
`ifdef LCD_SEQ_AUTO_REFRESH_EN
  ,
  parameter int REFRESH    = 5000000
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic [6:0]  i_addr,
  output logic [10:0] o_comm,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_done
);

  localparam int MAXW = (WAIT_LONG > POWERUP) ? WAIT_LONG : POWERUP;
  localparam int CW   = $clog2(MAXW) + 1;
  localparam logic [CW-1:0] SHORT_LD = CW'(WAIT_SHORT - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(WAIT_LONG - 1);
  localparam logic [CW-1:0] PWR_LD   = CW'(POWERUP - 1);
  localparam logic [7:0]    LAST_SLOT = 8'(SIZE - 1);

  lcd_state_e  state_q, state_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic [7:0]  slot_q, slot_d;
  logic [6:0]  addr_q, addr_d;
  logic        done_q, done_d;
  logic        tmr_load;
  logic [CW-1:0] tmr_val;
  logic        tmr_zero;
  logic [7:0]  init_op;
  logic        auto_start;

  lcd_wait_timer #(.W(CW), .RESET_VAL(PWR_LD)) u_timer (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign init_op = init_rom(init_idx_q);

`ifdef LCD_SEQ_AUTO_REFRESH_EN
  localparam int RCW = $clog2(REFRESH) + 1;
  localparam logic [RCW-1:0] REF_LD = RCW'(REFRESH - 1);

  logic [RCW-1:0] ref_q, ref_d;
  logic           ref_running;
  logic           update_start;

  assign ref_running  = (state_q != ST_POWERUP) && (state_q != ST_INIT_ISSUE) &&
                        (state_q != ST_INIT_WAIT);
  assign update_start = (state_q == ST_IDLE) && (state_d == ST_ADDR_ISSUE);
  assign auto_start   = (ref_q == '0) && !i_req;

  always_comb begin
    ref_d = ref_q;
    if (update_start) begin
      ref_d = REF_LD;
    end else if (ref_running && ref_q != '0) begin
      ref_d = ref_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ref_q <= REF_LD;
    end else begin
      ref_q <= ref_d;
    end
  end
`else
  assign auto_start = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    slot_d     = slot_q;
    addr_d     = addr_q;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = SHORT_LD;
    o_comm     = IDLE_WORD;
    o_ready    = 1'b0;
    o_busy     = 1'b1;

    case (state_q)
      ST_POWERUP: begin
        if (tmr_zero) begin
          init_idx_d = 2'd0;
          state_d    = ST_INIT_ISSUE;
        end
      end
      ST_INIT_ISSUE: begin
        o_comm   = {3'b000, init_op};
        tmr_load = 1'b1;
        tmr_val  = (init_op == OP_CLEAR) ? LONG_LD : SHORT_LD;
        state_d  = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (tmr_zero) begin
          if (init_idx_q == 2'(INIT_LEN - 1)) begin
            state_d = ST_IDLE;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            state_d    = ST_INIT_ISSUE;
          end
        end
      end
      ST_IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
        // External request wins over a refresh expiring in the same cycle
        if (i_req) begin
          addr_d  = i_addr;
          state_d = ST_ADDR_ISSUE;
        end else if (auto_start) begin
          addr_d  = 7'h00;
          state_d = ST_ADDR_ISSUE;
        end
      end
      ST_ADDR_ISSUE: begin
        o_comm   = {3'b000, OP_SET_DDRAM | {1'b0, addr_q}};
        tmr_load = 1'b1;
        state_d  = ST_ADDR_WAIT;
      end
      ST_ADDR_WAIT: begin
        if (tmr_zero) begin
          slot_d  = 8'd1;
          state_d = ST_DATA_ISSUE;
        end
      end
      ST_DATA_ISSUE: begin
        o_comm          = 11'h000;
        o_comm[SEL_BIT] = 1'b1;
        o_comm[RW_BIT]  = 1'b0;
        o_comm[RS_BIT]  = 1'b1;
        o_comm[7:0]     = slot_q - 8'd1;
        tmr_load        = 1'b1;
        state_d         = ST_DATA_WAIT;
      end
      ST_DATA_WAIT: begin
        if (tmr_zero) begin
          if (slot_q == LAST_SLOT) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            slot_d  = slot_q + 8'd1;
            state_d = ST_DATA_ISSUE;
          end
        end
      end
      default: state_d = ST_POWERUP;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_POWERUP;
      init_idx_q <= 2'd0;
      slot_q     <= 8'd0;
      addr_q     <= 7'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      slot_q     <= slot_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
    end
  end

  assign o_done = done_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - directed self-checking bench for lcd_sequencer
module tb_lcd_sequencer;

  localparam int SIZE = 4;
  localparam int WS   = 4;
  localparam int WL   = 10;
  localparam int PU   = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [6:0]  i_addr = 7'h00;
  logic [10:0] o_comm;
  logic        o_ready, o_busy, o_done;

  int n_checks = 0;
  int n_errors = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  lcd_sequencer #(
    .SIZE       (SIZE),
    .WAIT_SHORT (WS),
    .WAIT_LONG  (WL),
    .POWERUP    (PU)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .o_comm  (o_comm),
    .o_ready (o_ready),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always @(negedge clk) if (o_done) done_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts idle-word cycles before the next non-idle word, then checks the word
  task automatic next_word(input string tag, input int gap_exp, input logic [10:0] w_exp);
    int gap;
    gap = 0;
    @(negedge clk);
    while (o_comm == 11'h200 && gap < 400) begin
      gap++;
      @(negedge clk);
    end
    check({tag, " gap"}, 32'(gap), 32'(gap_exp));
    check({tag, " word"}, 32'(o_comm), 32'(w_exp));
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!o_ready && c < 400);
    check({tag, " ready cycles"}, 32'(c), 32'(exp_cycles));
    check({tag, " busy low"}, 32'(o_busy), 32'(0));
  endtask

  task automatic wait_done(input string tag, input int exp_cycles);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!o_done && c < 400);
    check({tag, " done cycles"}, 32'(c), 32'(exp_cycles));
    check({tag, " ready at done"}, 32'(o_ready), 32'(1));
    check({tag, " busy at done"}, 32'(o_busy), 32'(0));
    @(negedge clk);
    check({tag, " done one cycle"}, 32'(o_done), 32'(0));
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({tag, " rst comm"}, 32'(o_comm), 32'h200);
    check({tag, " rst ready"}, 32'(o_ready), 32'(0));
    check({tag, " rst busy"}, 32'(o_busy), 32'(1));
    check({tag, " rst done"}, 32'(o_done), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_init(input string tag);
    next_word({tag, " fset"},  PU, 11'h038);
    next_word({tag, " dispon"}, WS, 11'h00C);
    next_word({tag, " clear"},  WS, 11'h001);
    next_word({tag, " entry"},  WL, 11'h006);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int busy_words;

    apply_reset("por");
    run_init("init1");
    wait_ready("init1", WS + 1);

    // Basic update at 0x40
    i_req  = 1'b1;
    i_addr = 7'h40;
    next_word("upd40 addr", 0, 11'h0C0);
    i_req  = 1'b0;
    i_addr = 7'h7F;
    next_word("upd40 s1", WS, 11'h500);
    next_word("upd40 s2", WS, 11'h501);
    next_word("upd40 s3", WS, 11'h502);
    wait_done("upd40", WS + 1);

    // Request held high through init and into an update
    i_req  = 1'b1;
    i_addr = 7'h05;
    apply_reset("held");
    run_init("init2");
    next_word("held addr", WS + 1, 11'h085);
    next_word("held s1", WS, 11'h500);
    next_word("held s2", WS, 11'h501);
    i_req = 1'b0;
    next_word("held s3", WS, 11'h502);
    wait_done("held", WS + 1);
    busy_words = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_comm != 11'h200) busy_words++;
    end
    check("held no extra update", 32'(busy_words), 32'(0));

    // Reset in the middle of a data wait
    i_req  = 1'b1;
    i_addr = 7'h12;
    next_word("mid addr", 0, 11'h092);
    i_req = 1'b0;
    next_word("mid s1", WS, 11'h500);
    @(negedge clk);
    @(negedge clk);
    apply_reset("mid");
    run_init("init3");
    wait_ready("init3", WS + 1);

    check("done pulse total", 32'(done_pulses), 32'(2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
